// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping bus controller: op codes, bus layout and FSM states.
package snoop_bus_pkg;

    localparam int unsigned BUS_W        = 24;
    localparam int unsigned WB_PAYLOAD_W = 10;

    typedef enum logic [1:0] {
        OP_RM   = 2'd0,
        OP_WM   = 2'd1,
        OP_INV  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    // Field order fixes the bit positions: [23] valid, [22:21] op, [20:18] tag, [17:11] data,
    // [10] wb, [9:7] wb tag, [6:0] wb data.
    typedef struct packed {
        logic       valid;
        op_e        op;
        logic [2:0] tag;
        logic [6:0] data;
        logic       wb;
        logic [2:0] wb_tag;
        logic [6:0] wb_data;
    } bus_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNOOP = 3'd1,
        ST_WB    = 3'd2,
        ST_MEM   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bus word carrying the request header, with an optional writeback payload attached.
    function automatic bus_t make_bus(input bus_t req, input logic wb,
                                      input logic [WB_PAYLOAD_W-1:0] payload);
        bus_t b;
        b       = req;
        b.valid = 1'b1;
        b.wb    = wb;
        {b.wb_tag, b.wb_data} = payload;
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [IDX_W-1:0] idx_c
);

    int k;

    // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        k       = 0;
        for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
            k = (int'(ptr) + off) % int'(N_REQ);
            if (req[IDX_W'(k)]) begin
                grant_c              = '0;
                grant_c[IDX_W'(k)]   = 1'b1;
                idx_c                = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping bus controller: arbitrates caches, broadcasts for snoop, inserts writebacks, waits on memory.
module snoop_bus_controller
    import snoop_bus_pkg::*;
#(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic [N_REQ-1:0]       i_Req,
    input  logic [24*N_REQ-1:0]    i_Msg,
    input  logic [N_REQ-1:0]       i_Snoop_WB,
    input  logic [24*N_REQ-1:0]    i_Snoop_Msg,
    input  logic [BUS_W-1:0]       i_Mem_Bus,
    output logic [BUS_W-1:0]       o_Bus,
    output logic [N_REQ-1:0]       o_Grant,
    output logic                   o_Snoop_En,
    output logic [BUS_W-1:0]       o_Resp,
    output logic [N_REQ-1:0]       o_Done
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    state_e                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        owner;
    logic [CNT_W-1:0]        cnt;
    bus_t                    req_msg;

    logic [N_REQ-1:0]        arb_grant_c;
    logic [IDX_W-1:0]        arb_idx_c;
    bus_t                    slot_c;
    logic [N_REQ-1:0]        snoop_mask_c;
    logic                    wb_hit_c;
    logic [WB_PAYLOAD_W-1:0] wb_sel_c;
    logic                    unused_snoop_bits;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (i_Req),
        .ptr     (rr_ptr),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c)
    );

    assign slot_c            = bus_t'(i_Msg[24*arb_idx_c +: 24]);
    assign snoop_mask_c      = i_Snoop_WB & ~o_Grant;
    assign unused_snoop_bits = ^i_Snoop_Msg;

    // Lowest-index foreign snooper holding a modified copy supplies the writeback.
    always_comb begin
        wb_hit_c = 1'b0;
        wb_sel_c = '0;
        for (int s = int'(N_REQ) - 1; s >= 0; s--) begin
            if (snoop_mask_c[s]) begin
                wb_hit_c = 1'b1;
                wb_sel_c = i_Snoop_Msg[24*s +: WB_PAYLOAD_W];
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            cnt        <= '0;
            req_msg    <= '0;
            o_Bus      <= '0;
            o_Grant    <= '0;
            o_Snoop_En <= 1'b0;
            o_Resp     <= '0;
            o_Done     <= '0;
        end else begin
            o_Done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|i_Req) begin
                        owner      <= arb_idx_c;
                        req_msg    <= slot_c;
                        o_Grant    <= arb_grant_c;
                        o_Bus      <= make_bus(slot_c, 1'b0, '0);
                        o_Snoop_En <= 1'b1;
                        state      <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    o_Snoop_En <= 1'b0;
                    if (wb_hit_c) begin
                        o_Bus <= make_bus(req_msg, 1'b1, wb_sel_c);
                        state <= ST_WB;
                    end else if (req_msg.op == OP_RM) begin
                        o_Bus <= make_bus(req_msg, 1'b0, '0);
                        cnt   <= CNT_W'(MEM_WAIT - 1);
                        state <= ST_MEM;
                    end else begin
                        o_Bus  <= '0;
                        o_Resp <= req_msg;
                        o_Done <= o_Grant;
                        state  <= ST_DONE;
                    end
                end
                ST_WB: begin
                    if (req_msg.op == OP_RM) begin
                        o_Bus <= make_bus(req_msg, 1'b0, '0);
                        cnt   <= CNT_W'(MEM_WAIT - 1);
                        state <= ST_MEM;
                    end else begin
                        o_Bus  <= '0;
                        o_Resp <= req_msg;
                        o_Done <= o_Grant;
                        state  <= ST_DONE;
                    end
                end
                ST_MEM: begin
                    if (cnt == '0) begin
                        o_Bus  <= '0;
                        o_Resp <= i_Mem_Bus;
                        o_Done <= o_Grant;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    o_Grant <= '0;
                    rr_ptr  <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Randomized self-checking bench for snoop_bus_controller against a transaction-level trace model.
module tb_snoop_bus_controller;

    localparam int unsigned N_REQ    = 3;
    localparam int unsigned MEM_WAIT = 2;
    localparam int unsigned VW       = 24 + 2*N_REQ + 1;

    logic                   clock;
    logic                   reset_n;
    logic [N_REQ-1:0]       req;
    logic [24*N_REQ-1:0]    msg;
    logic [N_REQ-1:0]       snoop_wb;
    logic [24*N_REQ-1:0]    snoop_msg;
    logic [23:0]            mem_bus;
    logic [23:0]            bus;
    logic [N_REQ-1:0]       grant;
    logic                   snoop_en;
    logic [23:0]            resp;
    logic [N_REQ-1:0]       done;

    int errors = 0;
    int checks = 0;
    int ptr    = 0;

    snoop_bus_controller #(
        .N_REQ    (N_REQ),
        .MEM_WAIT (MEM_WAIT)
    ) dut (
        .i_Clock     (clock),
        .i_Reset_n   (reset_n),
        .i_Req       (req),
        .i_Msg       (msg),
        .i_Snoop_WB  (snoop_wb),
        .i_Snoop_Msg (snoop_msg),
        .i_Mem_Bus   (mem_bus),
        .o_Bus       (bus),
        .o_Grant     (grant),
        .o_Snoop_En  (snoop_en),
        .o_Resp      (resp),
        .o_Done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [23:0] mk_msg(input logic [1:0] op, input logic [2:0] tag,
                                           input logic [6:0] data);
        return {1'b1, op, tag, data, 11'h0};
    endfunction

    function automatic logic [24*N_REQ-1:0] rand_slots();
        logic [24*N_REQ-1:0] v;
        for (int k = 0; k < int'(N_REQ); k++) v[24*k +: 24] = 24'($urandom());
        return v;
    endfunction

    function automatic int pick(input logic [N_REQ-1:0] r, input int p);
        for (int off = 0; off < int'(N_REQ); off++)
            if (r[(p + off) % int'(N_REQ)]) return (p + off) % int'(N_REQ);
        return 0;
    endfunction

    // Runs one transaction from an IDLE negedge; returns at the negedge of the following IDLE cycle.
    task automatic run_txn(input logic [N_REQ-1:0] r, input logic [24*N_REQ-1:0] m,
                           input logic [N_REQ-1:0] wb, input logic [24*N_REQ-1:0] sm,
                           input logic [23:0] mem, input bit hold, input string name);
        logic [VW-1:0]    exp_q[$];
        logic [VW-1:0]    act;
        logic [N_REQ-1:0] g;
        logic [N_REQ-1:0] zero_n;
        logic [23:0]      rm;
        logic [11:0]      hdr;
        logic [9:0]       wbp;
        logic [23:0]      exp_resp;
        bit               wb_taken;
        int               owner;
        owner    = pick(r, ptr);
        rm       = m[24*owner +: 24];
        hdr      = rm[22:11];
        g        = N_REQ'(1) << owner;
        zero_n   = '0;
        wb_taken = 1'b0;
        wbp      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (wb[k] && k != owner && !wb_taken) begin
                wb_taken = 1'b1;
                wbp      = sm[24*k +: 10];
            end
        end
        exp_q.push_back({1'b1, hdr, 11'h0, g, 1'b1, zero_n});
        if (wb_taken) exp_q.push_back({1'b1, hdr, 1'b1, wbp, g, 1'b0, zero_n});
        if (rm[22:21] == 2'd0)
            for (int w = 0; w < int'(MEM_WAIT); w++) exp_q.push_back({1'b1, hdr, 11'h0, g, 1'b0, zero_n});
        exp_q.push_back({24'h0, g, 1'b0, g});
        exp_q.push_back({24'h0, zero_n, 1'b0, zero_n});
        exp_resp = (rm[22:21] == 2'd0) ? mem : rm;

        req = r; msg = m; snoop_wb = wb; snoop_msg = sm; mem_bus = mem;
        @(posedge clock);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            if (i == 0) begin
                if (!hold) req = '0;
                msg = rand_slots();
            end
            if (i == 1) begin
                snoop_msg = rand_slots();
                snoop_wb  = N_REQ'($urandom());
            end
            act = {bus, grant, snoop_en, done};
            checks++;
            if (act !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d bus/grant/snoop_en/done: got %h want %h", name, i, act, exp_q[i]);
            end
            if (i == exp_q.size() - 2) begin
                checks++;
                if (resp !== exp_resp) begin
                    errors++;
                    $display("FAIL %s resp: got %h want %h", name, resp, exp_resp);
                end
            end
        end
        ptr = (owner + 1) % int'(N_REQ);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req = '0; msg = '0; snoop_wb = '0; snoop_msg = '0; mem_bus = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ptr = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        req = 3'b111; msg = rand_slots(); snoop_wb = '0; snoop_msg = '0; mem_bus = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus, grant, snoop_en, done, resp} !== '0) begin
            errors++;
            $display("FAIL reset_async outputs: got %h want 0", {bus, grant, snoop_en, done, resp});
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus, grant, snoop_en, done, resp} !== '0) begin
            errors++;
            $display("FAIL reset_held outputs: got %h want 0", {bus, grant, snoop_en, done, resp});
        end
        req = '0;
        reset_n = 1'b1;
        ptr = 0;
    endtask

    task automatic test_rm_basic();
        logic [24*N_REQ-1:0] m;
        m = rand_slots();
        m[23:0] = mk_msg(2'd0, 3'd3, 7'h55);
        run_txn(3'b001, m, 3'b000, rand_slots(), 24'hABCDEF, 1'b0, "rm_basic");
    endtask

    task automatic test_rr_order();
        do_reset();
        for (int t = 0; t < 4; t++)
            run_txn(3'b111, rand_slots(), 3'b000, rand_slots(), 24'($urandom()), t < 3, "rr_order");
    endtask

    task automatic test_snoop_wb();
        logic [24*N_REQ-1:0] m;
        logic [24*N_REQ-1:0] sm;
        do_reset();
        m = rand_slots();
        m[23:0] = mk_msg(2'd0, 3'd6, 7'h1A);
        sm = rand_slots();
        sm[24 +: 10] = 10'h2A5;
        sm[48 +: 10] = 10'h15A;
        run_txn(3'b001, m, 3'b110, sm, 24'h123456, 1'b0, "snoop_wb");
    endtask

    task automatic test_own_wb_masked();
        logic [24*N_REQ-1:0] m;
        do_reset();
        m = rand_slots();
        m[24 +: 24] = mk_msg(2'd1, 3'd2, 7'h3C);
        run_txn(3'b010, m, 3'b010, rand_slots(), 24'h777777, 1'b0, "own_wb_masked");
    endtask

    task automatic test_reset_mid_mem();
        logic [24*N_REQ-1:0] m;
        do_reset();
        m = rand_slots();
        m[23:0] = mk_msg(2'd1, 3'd1, 7'h11);
        run_txn(3'b001, m, 3'b000, rand_slots(), 24'h0, 1'b0, "pre_abort");
        m[24 +: 24] = mk_msg(2'd0, 3'd5, 7'h22);
        req = 3'b010; msg = m; snoop_wb = '0; mem_bus = 24'hFEDCBA;
        @(posedge clock);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus, grant, snoop_en, done, resp} !== '0) begin
            errors++;
            $display("FAIL abort_async outputs: got %h want 0", {bus, grant, snoop_en, done, resp});
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (done !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL abort_no_done done/grant: got %h/%h want 0/0", done, grant);
        end
        reset_n = 1'b1;
        ptr = 0;
        run_txn(3'b111, rand_slots(), 3'b000, rand_slots(), 24'($urandom()), 1'b0, "after_abort");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++)
            run_txn(N_REQ'($urandom_range(1, 7)), rand_slots(), N_REQ'($urandom()), rand_slots(),
                    24'($urandom()), (t < 39) && ($urandom_range(0, 1) == 1), "random");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int t = 0; t < 6; t++)
            run_txn(N_REQ'($urandom_range(1, 7)), rand_slots(), N_REQ'($urandom()), rand_slots(),
                    24'($urandom()), t < 5, "back_to_back");
    endtask

    initial begin
        test_reset();
        test_rm_basic();
        test_rr_order();
        test_snoop_wb();
        test_own_wb_masked();
        test_reset_mid_mem();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snoop_bus_controller.md
SNOOP_BUS_CONTROLLER -- requirements
Module: snoop_bus_controller

Interface
REQ-001 Parameter N_REQ SHALL be as follows: default 3; number of cache requesters/snoopers.
REQ-002 Parameter MEM_WAIT SHALL be as follows: default 2, minimum 1; cycles o_Bus is held before i_Mem_Bus is sampled.
REQ-003 i_Clock SHALL be: input, 1 bit, single rising-edge clock.
REQ-004 i_Reset_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 i_Req SHALL be: input, N_REQ bits, level request per cache.
REQ-006 i_Msg SHALL be: input, 24*N_REQ bits, request message of cache k at [24k+23:24k].
REQ-007 i_Snoop_WB SHALL be: input, N_REQ bits, snooper k holds a modified copy of the broadcast tag.
REQ-008 i_Snoop_Msg SHALL be: input, 24*N_REQ bits, writeback payload of snooper k; only [9:0] used.
REQ-009 i_Mem_Bus SHALL be: input, 24 bits, memory reply.
REQ-010 o_Bus SHALL be: output, 24 bits, shared bus to memory and snoopers.
REQ-011 o_Grant SHALL be: output, N_REQ bits, one-hot current bus owner.
REQ-012 o_Snoop_En SHALL be: output, 1 bit, snoopers evaluate o_Bus this cycle.
REQ-013 o_Resp SHALL be: output, 24 bits, reply to owner, valid with o_Done.
REQ-014 o_Done SHALL be: output, N_REQ bits, one-cycle completion pulse to owner.

Function
REQ-015 Bus format SHALL be: [23] valid; [22:21] op (0 RM, 1 WM, 2 INV, 3 reserved); [20:18] tag; [17:11] data; [10] WB; [9:7] WB tag; [6:0] WB data.
REQ-016 FSM states SHALL be IDLE, SNOOP, WB, MEM and DONE.
REQ-017 IDLE SHALL drive o_Bus=0 and o_Grant=0, and SHALL exit only when any i_Req bit is set.
REQ-018 On exit from IDLE, the winner SHALL be the first set i_Req bit at or above rr_ptr, wrapping N_REQ-1 to 0; its i_Msg slot SHALL be latched, o_Grant SHALL be set, and the next state SHALL be SNOOP.
REQ-019 SNOOP SHALL last one cycle and drive o_Bus={1,op,tag,data,0,0,0} with o_Snoop_En=1.
REQ-020 In SNOOP, the owner's own i_Snoop_WB bit SHALL be masked; if any other bit is set, the lowest-index snooper's i_Snoop_Msg[9:0] SHALL be latched and the next state SHALL be WB.
REQ-021 If no other i_Snoop_WB bit is set in SNOOP, RM SHALL go to MEM and WM/INV/reserved SHALL go to DONE.
REQ-022 WB SHALL last one cycle and drive o_Bus={1,op,tag,data,1,wbtag,wbdata}; RM SHALL then go to MEM, all other ops to DONE.
REQ-023 MEM SHALL drive o_Bus={1,op,tag,data,0,0,0} for exactly MEM_WAIT cycles, counted down from MEM_WAIT-1, and SHALL capture i_Mem_Bus into o_Resp in the last cycle.
REQ-024 DONE SHALL pulse o_Done[owner] for one cycle, drive o_Bus=0, set rr_ptr=(owner+1) mod N_REQ, and go to IDLE with o_Grant cleared.
REQ-025 For non-RM ops, o_Resp SHALL equal the latched request message.
REQ-026 RM latency SHALL be 1+1+MEM_WAIT+1 cycles from the IDLE exit edge to o_Done (5 at default), plus 1 cycle when WB is taken.
REQ-027 Deassertion of i_Req by the owner mid-transaction SHALL be ignored; the transaction SHALL complete.
REQ-028 A request asserted during DONE SHALL be arbitrated only from IDLE, giving at least one idle cycle between transactions.
REQ-029 i_Msg and i_Snoop_Msg SHALL be sampled only at the IDLE exit and SNOOP cycles respectively.

Reset
REQ-030 While i_Reset_n=0, the block SHALL asynchronously set state=IDLE, rr_ptr=0, counter=0, latches=0, and drive o_Bus, o_Grant, o_Snoop_En, o_Resp and o_Done to 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no o_Done pulse.

Structure
REQ-032 Package snoop_bus_pkg SHALL hold the op codes, bus field bit positions and the FSM state encoding.
REQ-033 Sub-module rr_arbiter SHALL implement the combinational round-robin pick from i_Req and rr_ptr, producing a one-hot grant and an index.

Verification
REQ-034 i_Req=001 with RM tag 3 and no snoop WB -> o_Bus valid RM tag 3 for 1+2 cycles; o_Done=001 at cycle 5 with o_Resp=i_Mem_Bus.
REQ-035 i_Req=111 held continuously from reset -> grant order 001, 010, 100, 001.
REQ-036 Owner 0 RM, i_Snoop_WB=110 -> snooper 1 payload on o_Bus with [10]=1 for one cycle; o_Done at cycle 6.
REQ-037 Owner 1 WM with i_Snoop_WB=010 (own bit only) -> no WB state; o_Done=010 at cycle 3 with o_Resp=request message.
REQ-038 i_Reset_n low during MEM -> all outputs 0 immediately; no o_Done; next request is granted from rr_ptr=0.
